board_engine_nxn: RTL and testbench
===================================

Name: board_engine_nxn

Overview:
- Parametrised successor to the 3x3 tic-tac-toe core. Supports an NxN board with a K-in-a-row win condition.
- Accepts moves through a valid/ready handshake and validates each move against the registered board state and turn.
- Runs a multi-cycle line check around the last stone instead of a flat combinational win checker.
- Continuously streams board cells on a scan port for the output pins.
- Sits between the pad input logic and the pad output mux.

Parameters:
- N, 3, board edge length; legal range 2..15.
- K, 3, run length needed to win; legal range 2..N.
- CW, $clog2(N) (minimum 1), row/column index width; derived, never overridden.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears board, turn, FSM, scan counter.
- move_valid  in  1  move request present.
- move_ready  out  1  high only in IDLE.
- move_player  in  2  10=X, 01=O; 00/11 illegal.
- move_row  in  CW  target row.
- move_col  in  CW  target column.
- resp_valid  out  1  one-cycle pulse per accepted handshake.
- resp_code  out  3  0 OK, 1 game over, 2 parse, 3 turn, 4 occupied; valid with resp_valid.
- turn  out  2  player to move: 10=X, 01=O.
- win  out  2  00 none, 10 X wins, 01 O wins, 11 tie.
- scan_row  out  CW  row of cell currently streamed.
- scan_col  out  CW  column of cell currently streamed.
- scan_cell  out  2  contents of (scan_row, scan_col).

Behaviour:
- Reset values:
  - Board all 00, turn=10, win=00.
  - FSM=IDLE, move_ready=1, resp_valid=0, resp_code=0.
  - scan_row=scan_col=0, move_count=0.
- Cell encoding: 00 empty, 10 X, 01 O. The value 11 is never stored.
- Handshake: a move is accepted on a rising edge where move_valid&move_ready. There is no backpressure on resp. Requests while move_ready=0 are ignored and never queued.
- Error evaluation happens in the acceptance cycle, against the registered board. When more than one error applies, the highest-priority one is reported:
  1. Game over: win!=00.
  2. Parse: move_row>=N, move_col>=N, or move_player in {00,11}.
  3. Turn: move_player!=turn.
  4. Occupied: addressed cell !=00.
- FSM states:
  - IDLE:
    - On acceptance with an error -> RESP with that code; board and turn are unchanged.
    - On acceptance with no error -> write the cell and capture last_row/last_col/player on the same edge, increment move_count, then -> CHECK.
  - CHECK:
    - Directions are walked in the order (0,+1), (+1,0), (+1,+1), (+1,-1). For each direction, run=1, then step outward in the + sense, then the - sense.
    - Each examined in-bounds cell costs one cycle. A step stops on out-of-bounds or on a cell != player. An out-of-bounds step costs no cycle.
    - If run reaches K -> set win=player and go to RESP immediately (early exit).
    - When all directions are exhausted -> RESP. In that case, if move_count==N*N set win=11; otherwise win is unchanged.
  - RESP:
    - resp_valid=1 for exactly one cycle, resp_code as determined above.
    - If the code is OK and win==00, toggle turn on this edge.
    - -> IDLE.
- Latency: resp_valid asserts 1 cycle after acceptance on the error path, and at most 8*(K-1)+2 cycles after acceptance on the OK path.
  - Benches check this bound only, never an exact count.
  - win is updated no later than the cycle resp_valid is high.
- A win on the board-filling move reports the winner, not a tie.
- After win!=00:
  - Every move gets code 1.
  - turn freezes.
  - Only reset restarts the game.
- Reset asserted in any state, including mid-CHECK, takes priority on that edge. The in-flight check is abandoned with no resp_valid, and all reset values apply on the next cycle.
- Scan port:
  - Advances every clock in row-major order.
  - (r,N-1) -> (r+1,0), and wraps (N-1,N-1) -> (0,0).
  - scan_cell is combinational from the registered board at the current scan coordinates.
  - A move written on edge t shows up on scan from cycle t+1.

Decomposition:
- Package board_pkg, containing:
  - cell_t encoding (EMPTY, X, O).
  - win codes.
  - resp_code constants.
  - FSM state enum (IDLE, CHECK, RESP).
  - Direction table as constant arrays of signed row/col deltas.
- Sub-module board_scan_out: holds the scan row/col counter with wrap logic and the cell select mux (parameters N, CW).
- Everything else stays in board_engine_nxn.

Test Plan:
- N=3,K=3 row win: moves X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) -> five resps, all code 0; after the fifth, win=10 and turn=10 stays frozen. Then O(2,2) -> code 1, board unchanged.
- Occupied and turn errors: X(1,1), then O(1,1) -> code 4, turn=01. Then X(0,0) -> code 3. Then O with row=3 (N=3) -> code 2. Then player=11 at (0,0) -> code 2. Board holds only (1,1)=10 throughout.
- Draw: X(0,0), O(0,1), X(0,2), O(1,1), X(1,0), O(1,2), X(2,1), O(2,0), X(2,2) -> win=11 after the ninth resp. The tenth move -> code 1.
- N=5,K=4 anti-diagonal with a middle completion: X at (0,4),(1,3),(3,1) (O replies elsewhere), then X at (2,2) -> win=10, resp within 26 cycles of acceptance.
- Reset mid-CHECK: assert reset for one cycle while in CHECK -> no resp_valid, board all 00, turn=10, win=00, move_ready=1, scan at (0,0) on the next cycle.
- Scan wrap, N=3: after reset, sample 10 cycles -> coordinates (0,0)…(2,2),(0,0). A cell written on edge t appears with value 10 the next time scan reaches it.

Source files
------------

// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_pkg
// Purpose  : Shared encodings for the NxN K-in-a-row board engine.
// Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      O     = 2'b01,
      X     = 2'b10
   } cell_t;

   localparam logic [1:0] c_win_none = 2'b00;
   localparam logic [1:0] c_win_x    = 2'b10;
   localparam logic [1:0] c_win_o    = 2'b01;
   localparam logic [1:0] c_win_tie  = 2'b11;

   localparam logic [2:0] c_resp_ok        = 3'd0;
   localparam logic [2:0] c_resp_game_over = 3'd1;
   localparam logic [2:0] c_resp_parse     = 3'd2;
   localparam logic [2:0] c_resp_turn      = 3'd3;
   localparam logic [2:0] c_resp_occupied  = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Line directions walked by the checker: row, column, diagonal, anti-diagonal.
   localparam logic signed [1:0] c_dir_dr [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
   localparam logic signed [1:0] c_dir_dc [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

endpackage
`default_nettype wire

// File: rtl/board_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : board_scan_out
// Purpose  : Row-major free-running scan of the board for the output pins.
// Revision : 1.0 - initial release
// ============================================================================
module board_scan_out #(
   parameter int N  = 3,
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    board [N][N],
   output logic [CW-1:0] scan_row,
   output logic [CW-1:0] scan_col,
   output logic [1:0]    scan_cell
);

   localparam logic [CW-1:0] c_last = CW'(N - 1);

   logic [CW-1:0] r_row;
   logic [CW-1:0] r_col;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row <= '0;
         r_col <= '0;
      end else if (r_col == c_last) begin
         r_col <= '0;
         r_row <= (r_row == c_last) ? '0 : r_row + CW'(1);
      end else begin
         r_col <= r_col + CW'(1);
      end
   end

   assign scan_row  = r_row;
   assign scan_col  = r_col;
   assign scan_cell = board[r_row][r_col];

endmodule
`default_nettype wire

// File: rtl/board_engine_nxn.sv
`default_nettype none
// ============================================================================
// Module   : board_engine_nxn
// Purpose  : NxN K-in-a-row move validator with a multi-cycle line checker.
// Revision : 1.0 - initial release
// ============================================================================
module board_engine_nxn
   import board_pkg::*;
#(
   parameter int N  = 3,
   parameter int K  = 3,
   parameter int CW = (N > 2) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          move_valid,
   output logic          move_ready,
   input  logic [1:0]    move_player,
   input  logic [CW-1:0] move_row,
   input  logic [CW-1:0] move_col,
   output logic          resp_valid,
   output logic [2:0]    resp_code,
   output logic [1:0]    turn,
   output logic [1:0]    win,
   output logic [CW-1:0] scan_row,
   output logic [CW-1:0] scan_col,
   output logic [1:0]    scan_cell
);

   localparam int PW  = CW + 2;
   localparam int CW1 = CW + 1;
   localparam int MCW = $clog2(N * N + 1);
   localparam int RW  = 5;

   localparam logic [CW1-1:0]       c_n     = CW1'(N);
   localparam logic signed [PW-1:0] c_n_s   = PW'(N);
   localparam logic [MCW-1:0]       c_cells = MCW'(N * N);
   localparam logic [RW-1:0]        c_k     = RW'(K);

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_board [N][N];
   logic [1:0]           r_turn;
   logic [1:0]           r_win;
   logic [1:0]           r_player;
   logic [2:0]           r_code;
   logic [CW-1:0]        r_last_row;
   logic [CW-1:0]        r_last_col;
   logic [MCW-1:0]       r_move_count;
   logic [3:0]           r_s;
   logic [RW-1:0]        r_run;
   logic signed [PW-1:0] r_pr;
   logic signed [PW-1:0] r_pc;

   logic                 w_parse;
   logic [2:0]           w_err;
   logic signed [PW-1:0] w_mv_r, w_mv_c, w_last_r, w_last_c;
   logic signed [PW-1:0] w_step_r, w_step_c, w_nxt_r, w_nxt_c;
   logic [3:0]           w_s0, w_ns;
   logic [1:0]           w_cell;
   logic                 w_match, w_hit, w_cont, w_done, w_full;
   logic [RW-1:0]        w_run_inc;

   function automatic logic in_bounds(input logic signed [PW-1:0] r,
                                      input logic signed [PW-1:0] c);
      return !r[PW-1] && (r < c_n_s) && !c[PW-1] && (c < c_n_s);
   endfunction

   function automatic logic signed [PW-1:0] step_of(input logic signed [1:0] d,
                                                    input logic neg);
      logic signed [PW-1:0] e;
      e = {{(PW-2){d[1]}}, d};
      return neg ? -e : e;
   endfunction

   // Sense index s = 2*direction + (1 for the minus sense); 8 means exhausted.
   // Senses whose first neighbour is off the board are skipped without a cycle.
   function automatic logic [3:0] first_sense(input logic signed [PW-1:0] br,
                                              input logic signed [PW-1:0] bc,
                                              input logic [3:0] from);
      logic [3:0] res;
      logic [3:0] si;
      res = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         si = 4'(i);
         if (si >= from &&
             in_bounds(br + step_of(c_dir_dr[si[2:1]], si[0]),
                       bc + step_of(c_dir_dc[si[2:1]], si[0])))
            res = si;
      end
      return res;
   endfunction

   assign w_mv_r   = {2'b00, move_row};
   assign w_mv_c   = {2'b00, move_col};
   assign w_last_r = {2'b00, r_last_row};
   assign w_last_c = {2'b00, r_last_col};

   assign w_parse = ({1'b0, move_row} >= c_n) || ({1'b0, move_col} >= c_n) ||
                    (move_player != X && move_player != O);

   always_comb begin
      w_err = c_resp_ok;
      if (r_win != c_win_none)
         w_err = c_resp_game_over;
      else if (w_parse)
         w_err = c_resp_parse;
      else if (move_player != r_turn)
         w_err = c_resp_turn;
      else if (r_board[move_row][move_col] != EMPTY)
         w_err = c_resp_occupied;
   end

   assign w_s0      = first_sense(w_mv_r, w_mv_c, 4'd0);
   assign w_cell    = r_board[r_pr[CW-1:0]][r_pc[CW-1:0]];
   assign w_step_r  = step_of(c_dir_dr[r_s[2:1]], r_s[0]);
   assign w_step_c  = step_of(c_dir_dc[r_s[2:1]], r_s[0]);
   assign w_nxt_r   = r_pr + w_step_r;
   assign w_nxt_c   = r_pc + w_step_c;
   assign w_match   = !r_s[3] && (w_cell == r_player);
   assign w_run_inc = r_run + RW'(1);
   assign w_hit     = w_match && (w_run_inc >= c_k);
   assign w_cont    = w_match && !w_hit && in_bounds(w_nxt_r, w_nxt_c);
   assign w_ns      = r_s[3] ? 4'd8 : first_sense(w_last_r, w_last_c, r_s + 4'd1);
   assign w_done    = !w_hit && !w_cont && w_ns[3];
   assign w_full    = (r_move_count == c_cells);

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (move_valid) w_next = (w_err == c_resp_ok) ? CHECK : RESP;
         CHECK:   if (w_hit || w_done) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      move_ready = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE:    move_ready = 1'b1;
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               r_board[r][c] <= EMPTY;
         r_turn       <= X;
         r_win        <= c_win_none;
         r_player     <= X;
         r_code       <= c_resp_ok;
         r_last_row   <= '0;
         r_last_col   <= '0;
         r_move_count <= '0;
         r_s          <= '0;
         r_run        <= '0;
         r_pr         <= '0;
         r_pc         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (move_valid) begin
                  r_code <= w_err;
                  if (w_err == c_resp_ok) begin
                     r_board[move_row][move_col] <= move_player;
                     r_last_row   <= move_row;
                     r_last_col   <= move_col;
                     r_player     <= move_player;
                     r_move_count <= r_move_count + MCW'(1);
                     r_s          <= w_s0;
                     r_run        <= RW'(1);
                     r_pr         <= w_mv_r + step_of(c_dir_dr[w_s0[2:1]], w_s0[0]);
                     r_pc         <= w_mv_c + step_of(c_dir_dc[w_s0[2:1]], w_s0[0]);
                  end
               end
            end
            CHECK: begin
               if (w_hit) begin
                  r_win <= r_player;
               end else if (w_cont) begin
                  r_run <= w_run_inc;
                  r_pr  <= w_nxt_r;
                  r_pc  <= w_nxt_c;
               end else begin
                  // The run carries into the minus sense of the same direction only.
                  r_s   <= w_ns;
                  r_run <= (w_ns[3:1] == r_s[3:1]) ? (w_match ? w_run_inc : r_run)
                                                   : RW'(1);
                  r_pr  <= w_last_r + step_of(c_dir_dr[w_ns[2:1]], w_ns[0]);
                  r_pc  <= w_last_c + step_of(c_dir_dc[w_ns[2:1]], w_ns[0]);
                  if (w_ns[3] && w_full)
                     r_win <= c_win_tie;
               end
            end
            RESP: begin
               if (r_code == c_resp_ok && r_win == c_win_none)
                  r_turn <= ~r_turn;
            end
            default: ;
         endcase
      end
   end

   assign turn      = r_turn;
   assign win       = r_win;
   assign resp_code = r_code;

   board_scan_out #(
      .N  (N),
      .CW (CW)
   ) u_scan (
      .clk       (clk),
      .reset     (reset),
      .board     (r_board),
      .scan_row  (scan_row),
      .scan_col  (scan_col),
      .scan_cell (scan_cell)
   );

endmodule
`default_nettype wire

// File: tb/tb_board_engine_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_engine_nxn
// Purpose  : Directed self-checking bench for a 3x3/K=3 and a 5x5/K=4 engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_engine_nxn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset3, mv3_valid, ready3, rv3;
   logic [1:0] mv3_player, mv3_row, mv3_col;
   logic [2:0] rc3;
   logic [1:0] turn3, win3, srow3, scol3, scell3;

   logic       reset5, mv5_valid, ready5, rv5;
   logic [1:0] mv5_player;
   logic [2:0] mv5_row, mv5_col;
   logic [2:0] rc5;
   logic [1:0] turn5, win5, scell5;
   logic [2:0] srow5, scol5;

   int         n_cmp = 0;
   int         n_err = 0;
   int         lat;
   logic [2:0] code;
   logic [1:0] cap3 [9];
   logic [1:0] exp3 [9];
   logic [5:0] mv [10];

   board_engine_nxn #(.N(3), .K(3)) dut3 (
      .clk(clk), .reset(reset3), .move_valid(mv3_valid), .move_ready(ready3),
      .move_player(mv3_player), .move_row(mv3_row), .move_col(mv3_col),
      .resp_valid(rv3), .resp_code(rc3), .turn(turn3), .win(win3),
      .scan_row(srow3), .scan_col(scol3), .scan_cell(scell3)
   );

   board_engine_nxn #(.N(5), .K(4)) dut5 (
      .clk(clk), .reset(reset5), .move_valid(mv5_valid), .move_ready(ready5),
      .move_player(mv5_player), .move_row(mv5_row), .move_col(mv5_col),
      .resp_valid(rv5), .resp_code(rc5), .turn(turn5), .win(win5),
      .scan_row(srow5), .scan_col(scol5), .scan_cell(scell5)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset3;
      @(negedge clk);
      reset3 = 1'b1; mv3_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset3 = 1'b0;
   endtask

   task automatic do_reset5;
      @(negedge clk);
      reset5 = 1'b1; mv5_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset5 = 1'b0;
   endtask

   // Issues one move and waits (bounded) for its response; code=7 on timeout.
   task automatic move3(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
      int w;
      code = 3'b111; lat = -1; w = 0;
      while (!ready3 && w < 40) begin @(negedge clk); w++; end
      mv3_player = p; mv3_row = r; mv3_col = c; mv3_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv3_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (rv3) begin code = rc3; lat = i; break; end
         @(negedge clk);
      end
      if (lat > 0) @(negedge clk);
   endtask

   task automatic move5(input logic [1:0] p, input logic [2:0] r, input logic [2:0] c);
      int w;
      code = 3'b111; lat = -1; w = 0;
      while (!ready5 && w < 60) begin @(negedge clk); w++; end
      mv5_player = p; mv5_row = r; mv5_col = c; mv5_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv5_valid = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (rv5) begin code = rc5; lat = i; break; end
         @(negedge clk);
      end
      if (lat > 0) @(negedge clk);
   endtask

   task automatic capture3;
      int w;
      for (int k = 0; k < 9; k++) cap3[k] = 2'bxx;
      w = 0;
      while (!(srow3 == 2'd0 && scol3 == 2'd0) && w < 20) begin @(negedge clk); w++; end
      for (int k = 0; k < 9; k++) begin
         cap3[int'(srow3) * 3 + int'(scol3)] = scell3;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset3 = 1'b1; reset5 = 1'b1; mv3_valid = 1'b0; mv5_valid = 1'b0;
      mv3_player = 2'b00; mv3_row = 2'd0; mv3_col = 2'd0;
      mv5_player = 2'b00; mv5_row = 3'd0; mv5_col = 3'd0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({ready3, rv3, rc3} !== 5'b10000) begin n_err++; $display("FAIL reset_hs3: got ready/valid/code %b expected 10000", {ready3, rv3, rc3}); end
      n_cmp++; if ({turn3, win3} !== 4'b1000) begin n_err++; $display("FAIL reset_turn_win3: got %b expected 1000", {turn3, win3}); end
      n_cmp++; if ({srow3, scol3} !== 4'b0000) begin n_err++; $display("FAIL reset_scan3: got %b expected 0000", {srow3, scol3}); end
      n_cmp++; if ({ready5, rv5, rc5, turn5, win5} !== 9'b10_000_1000) begin n_err++; $display("FAIL reset_state5: got %b expected 100001000", {ready5, rv5, rc5, turn5, win5}); end
      n_cmp++; if ({srow5, scol5, scell5} !== 8'b0) begin n_err++; $display("FAIL reset_scan5: got %b expected 00000000", {srow5, scol5, scell5}); end
      reset3 = 1'b0; reset5 = 1'b0;
      capture3;
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (cap3[k] !== 2'b00) begin n_err++; $display("FAIL reset_board cell %0d: got %b expected 00", k, cap3[k]); end
      end
   endtask

   task automatic test_scan_wrap;
      do_reset3;
      for (int j = 0; j < 10; j++) begin
         n_cmp++;
         if (int'(srow3) != (j % 9) / 3 || int'(scol3) != j % 3) begin
            n_err++; $display("FAIL scan_wrap step %0d: got (%0d,%0d) expected (%0d,%0d)", j, srow3, scol3, (j % 9) / 3, j % 3);
         end
         @(negedge clk);
      end
      move3(2'b10, 2'd1, 2'd2);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL scan_move_code: got %0d expected 0", code); end
      capture3;
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (cap3[k] !== ((k == 5) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL scan_cell %0d: got %b expected %b", k, cap3[k], (k == 5) ? 2'b10 : 2'b00); end
      end
   endtask

   task automatic test_row_win;
      do_reset3;
      mv[0] = {2'b10, 2'd0, 2'd0}; mv[1] = {2'b01, 2'd1, 2'd0};
      mv[2] = {2'b10, 2'd0, 2'd1}; mv[3] = {2'b01, 2'd1, 2'd1};
      mv[4] = {2'b10, 2'd0, 2'd2};
      for (int i = 0; i < 5; i++) begin
         move3(mv[i][5:4], mv[i][3:2], mv[i][1:0]);
         n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL row_win_code move %0d: got %0d expected 0", i, code); end
      end
      n_cmp++; if (win3 !== 2'b10) begin n_err++; $display("FAIL row_win_win: got %b expected 10", win3); end
      n_cmp++; if (turn3 !== 2'b10) begin n_err++; $display("FAIL row_win_turn: got %b expected 10", turn3); end
      move3(2'b01, 2'd2, 2'd2);
      n_cmp++; if (code !== 3'd1) begin n_err++; $display("FAIL row_win_gameover: got %0d expected 1", code); end
      n_cmp++; if ({turn3, win3} !== 4'b1010) begin n_err++; $display("FAIL row_win_frozen: got %b expected 1010", {turn3, win3}); end
      exp3 = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      capture3;
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (cap3[k] !== exp3[k]) begin n_err++; $display("FAIL row_win_board cell %0d: got %b expected %b", k, cap3[k], exp3[k]); end
      end
   endtask

   task automatic test_errors;
      do_reset3;
      move3(2'b10, 2'd1, 2'd1);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL err_first: got %0d expected 0", code); end
      n_cmp++; if (turn3 !== 2'b01) begin n_err++; $display("FAIL err_turn_after_x: got %b expected 01", turn3); end
      move3(2'b01, 2'd1, 2'd1);
      n_cmp++; if (code !== 3'd4) begin n_err++; $display("FAIL err_occupied: got %0d expected 4", code); end
      n_cmp++; if (turn3 !== 2'b01) begin n_err++; $display("FAIL err_turn_kept: got %b expected 01", turn3); end
      move3(2'b10, 2'd0, 2'd0);
      n_cmp++; if (code !== 3'd3) begin n_err++; $display("FAIL err_turn: got %0d expected 3", code); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL err_latency: got %0d expected 1", lat); end
      move3(2'b01, 2'd3, 2'd0);
      n_cmp++; if (code !== 3'd2) begin n_err++; $display("FAIL err_parse_row: got %0d expected 2", code); end
      move3(2'b11, 2'd0, 2'd0);
      n_cmp++; if (code !== 3'd2) begin n_err++; $display("FAIL err_parse_player: got %0d expected 2", code); end
      n_cmp++; if ({turn3, win3} !== 4'b0100) begin n_err++; $display("FAIL err_final_state: got %b expected 0100", {turn3, win3}); end
      capture3;
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (cap3[k] !== ((k == 4) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL err_board cell %0d: got %b expected %b", k, cap3[k], (k == 4) ? 2'b10 : 2'b00); end
      end
   endtask

   task automatic test_draw;
      do_reset3;
      mv[0] = {2'b10, 2'd0, 2'd0}; mv[1] = {2'b01, 2'd0, 2'd1};
      mv[2] = {2'b10, 2'd0, 2'd2}; mv[3] = {2'b01, 2'd1, 2'd1};
      mv[4] = {2'b10, 2'd1, 2'd0}; mv[5] = {2'b01, 2'd1, 2'd2};
      mv[6] = {2'b10, 2'd2, 2'd1}; mv[7] = {2'b01, 2'd2, 2'd0};
      mv[8] = {2'b10, 2'd2, 2'd2};
      for (int i = 0; i < 9; i++) begin
         move3(mv[i][5:4], mv[i][3:2], mv[i][1:0]);
         n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL draw_code move %0d: got %0d expected 0", i, code); end
         if (i == 7) begin
            n_cmp++; if (win3 !== 2'b00) begin n_err++; $display("FAIL draw_early_win: got %b expected 00", win3); end
         end
      end
      n_cmp++; if (win3 !== 2'b11) begin n_err++; $display("FAIL draw_tie: got %b expected 11", win3); end
      n_cmp++; if (turn3 !== 2'b10) begin n_err++; $display("FAIL draw_turn: got %b expected 10", turn3); end
      move3(2'b01, 2'd0, 2'd0);
      n_cmp++; if (code !== 3'd1) begin n_err++; $display("FAIL draw_gameover: got %0d expected 1", code); end
   endtask

   task automatic test_anti_diag;
      do_reset5;
      mv[0] = {2'b10, 2'd0, 2'd0}; mv[1] = {2'b01, 2'd0, 2'd0}; mv[2] = {2'b10, 2'd0, 2'd0};
      mv[3] = {2'b01, 2'd0, 2'd0}; mv[4] = {2'b10, 2'd0, 2'd0}; mv[5] = {2'b01, 2'd0, 2'd0};
      move5(2'b10, 3'd0, 3'd4);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m0: got %0d expected 0", code); end
      move5(2'b01, 3'd0, 3'd0);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m1: got %0d expected 0", code); end
      move5(2'b10, 3'd1, 3'd3);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m2: got %0d expected 0", code); end
      move5(2'b01, 3'd4, 3'd4);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m3: got %0d expected 0", code); end
      move5(2'b10, 3'd3, 3'd1);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m4: got %0d expected 0", code); end
      move5(2'b01, 3'd0, 3'd2);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_m5: got %0d expected 0", code); end
      n_cmp++; if (win5 !== 2'b00) begin n_err++; $display("FAIL diag_no_win_yet: got %b expected 00", win5); end
      move5(2'b10, 3'd2, 3'd2);
      n_cmp++; if (code !== 3'd0) begin n_err++; $display("FAIL diag_final_code: got %0d expected 0", code); end
      n_cmp++; if (lat < 1 || lat > 26) begin n_err++; $display("FAIL diag_latency: got %0d expected 1..26", lat); end
      n_cmp++; if ({win5, turn5} !== 4'b1010) begin n_err++; $display("FAIL diag_win: got win/turn %b expected 1010", {win5, turn5}); end
   endtask

   task automatic test_reset_mid_check;
      int seen;
      do_reset3;
      mv3_player = 2'b10; mv3_row = 2'd0; mv3_col = 2'd0; mv3_valid = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if ({ready3, rv3} !== 2'b00) begin n_err++; $display("FAIL midchk_in_check: got ready/valid %b expected 00", {ready3, rv3}); end
      reset3 = 1'b1; mv3_valid = 1'b0;
      @(posedge clk);
      #1;
      reset3 = 1'b0;
      n_cmp++; if ({ready3, rv3, turn3, win3} !== 6'b10_1000) begin n_err++; $display("FAIL midchk_state: got %b expected 101000", {ready3, rv3, turn3, win3}); end
      n_cmp++; if ({srow3, scol3} !== 4'b0000) begin n_err++; $display("FAIL midchk_scan: got %b expected 0000", {srow3, scol3}); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rv3) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midchk_no_resp: got %0d pulses expected 0", seen); end
      capture3;
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (cap3[k] !== 2'b00) begin n_err++; $display("FAIL midchk_board cell %0d: got %b expected 00", k, cap3[k]); end
      end
   endtask

   initial begin
      test_reset;
      test_scan_wrap;
      test_row_win;
      test_errors;
      test_draw;
      test_anti_diag;
      test_reset_mid_check;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
